fetch_sequencer: RTL and testbench

- Instruction-fetch control stage directly upstream of the program-counter register (load/inc/dec register, 11-bit default).
- Reads the PC value and issues memory read requests over a valid/ready handshake.
- Presents fetched instructions to the decode stage, and drives the PC register's load/inc/dec strobes and load data.
- Handles retry of erroring reads, jumps, single-step rewind and halt.

---
 rtl/fetch_sequencer.sv | 145 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch sequencer driving PC strobes and memory reads
//
// Ports:
//   clk, rst (async active-low)
//   start, halt                     - run control
//   pc_value / pc_in, pc_load,
//   pc_inc, pc_dec                  - PC register interface
//   mem_req_valid/ready, mem_addr   - read request
//   mem_rsp_valid/err/data          - read response (single cycle)
//   instr_valid/ready/data/addr     - fetched instruction to decode
//   jump_req, jump_addr, rewind     - redirect controls sampled at the instruction handshake
//   busy, fault                     - status
module fetch_sequencer #(
  parameter int ADDR_SIZE  = 11,
  parameter int INSTR_SIZE = 16,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt,
  input  logic [ADDR_SIZE-1:0]  pc_value,
  output logic [ADDR_SIZE-1:0]  pc_in,
  output logic                  pc_load,
  output logic                  pc_inc,
  output logic                  pc_dec,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_SIZE-1:0]  mem_addr,
  input  logic                  mem_rsp_valid,
  input  logic                  mem_rsp_err,
  input  logic [INSTR_SIZE-1:0] mem_rsp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [INSTR_SIZE-1:0] instr_data,
  output logic [ADDR_SIZE-1:0]  instr_addr,
  input  logic                  jump_req,
  input  logic [ADDR_SIZE-1:0]  jump_addr,
  input  logic                  rewind,
  output logic                  busy,
  output logic                  fault
);

  localparam int CW = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         retry_cnt, retry_nxt;
  // Address of the outstanding read; the PC may already have moved on by
  // the time the response arrives, so it cannot be re-read from pc_value.
  logic [ADDR_SIZE-1:0]  req_addr;
  logic                  rsp_ok;

  assign rsp_ok = (state == S_WAIT) && mem_rsp_valid && !mem_rsp_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      retry_cnt  <= '0;
      req_addr   <= '0;
      instr_data <= '0;
      instr_addr <= '0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      if (state == S_REQ && mem_req_ready) begin
        req_addr <= pc_value;
      end
      if (rsp_ok) begin
        instr_data <= mem_rsp_data;
        instr_addr <= req_addr;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    retry_nxt     = retry_cnt;
    pc_in         = '0;
    pc_load       = 1'b0;
    pc_inc        = 1'b0;
    pc_dec        = 1'b0;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    instr_valid   = 1'b0;
    busy          = 1'b0;
    fault         = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_REQ;
      end
      S_REQ: begin
        busy          = 1'b1;
        mem_req_valid = 1'b1;
        mem_addr      = pc_value;
        if (mem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (mem_rsp_valid) begin
          if (!mem_rsp_err) begin
            pc_inc    = 1'b1;
            retry_nxt = '0;
            state_nxt = S_HOLD;
          end else begin
            // PC was not incremented, so REQ re-issues the same address.
            retry_nxt = retry_cnt + CW'(1);
            state_nxt = (retry_nxt == CW'(MAX_RETRY)) ? S_FAULT : S_REQ;
          end
        end
      end
      S_HOLD: begin
        busy        = 1'b1;
        instr_valid = 1'b1;
        if (instr_ready) begin
          if (jump_req) begin
            pc_load = 1'b1;
            pc_in   = jump_addr;
          end else if (rewind) begin
            // PC already points past instr_addr; step back to re-fetch it.
            pc_dec = 1'b1;
          end
          state_nxt = halt ? S_IDLE : S_REQ;
        end
      end
      S_FAULT: begin
        fault = 1'b1;
        if (start) begin
          retry_nxt = '0;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard testbench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b1;
  logic [10:0] pc = 11'd0;
  logic [10:0] pc_in;
  logic        pc_load, pc_inc, pc_dec;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [10:0] mem_addr;
  logic        mem_rsp_valid = 1'b0;
  logic        mem_rsp_err = 1'b0;
  logic [15:0] mem_rsp_data = 16'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [15:0] instr_data;
  logic [10:0] instr_addr;
  logic        jump_req = 1'b0;
  logic [10:0] jump_addr = 11'd0;
  logic        rewind = 1'b0;
  logic        busy, fault;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pops = 0;
  int n_inc = 0, n_load = 0, n_dec = 0;
  int err_left = 0;
  logic rsp_block = 1'b0;
  logic pend = 1'b0;
  logic [10:0] pend_addr = 11'd0;
  logic pc_set = 1'b0;
  logic [10:0] pc_set_val = 11'd0;

  typedef struct packed {
    logic [10:0] addr;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];
  logic [10:0] req_log[$];
  int hs_cyc[$];

  fetch_sequencer #(.ADDR_SIZE(11), .INSTR_SIZE(16), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .pc_value(pc),
    .pc_in(pc_in), .pc_load(pc_load), .pc_inc(pc_inc), .pc_dec(pc_dec),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_err(mem_rsp_err), .mem_rsp_data(mem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_addr(instr_addr), .jump_req(jump_req), .jump_addr(jump_addr), .rewind(rewind),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_data(input logic [10:0] a);
    return (a == 11'h005) ? 16'hA5A5 : {5'h1B, a};
  endfunction

  // PC register: load > inc > dec, wrapping naturally.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pc_set)        pc <= pc_set_val;
    else if (pc_load)  pc <= pc_in;
    else if (pc_inc)   pc <= pc + 11'd1;
    else if (pc_dec)   pc <= pc - 11'd1;
    if (pc_load) n_load <= n_load + 1;
    if (pc_inc)  n_inc  <= n_inc + 1;
    if (pc_dec)  n_dec  <= n_dec + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic push_exp(input logic [10:0] a);
    exp_t e;
    e.addr = a;
    e.data = mem_data(a);
    exp_q.push_back(e);
  endtask

  // Memory: accepts per mem_req_ready, responds one cycle after acceptance.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      mem_rsp_data  = 16'd0;
      if (pend && !rsp_block) begin
        mem_rsp_valid = 1'b1;
        if (err_left > 0) begin
          mem_rsp_err  = 1'b1;
          mem_rsp_data = 16'hDEAD;
          err_left--;
        end else begin
          mem_rsp_data = mem_data(pend_addr);
        end
        pend = 1'b0;
      end
      if (rst && mem_req_valid && mem_req_ready) begin
        pend      = 1'b1;
        pend_addr = mem_addr;
        req_log.push_back(mem_addr);
      end
    end
  end

  // Monitor: compares each accepted instruction against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      chk("strobe_onehot", 32'($countones({pc_load, pc_inc, pc_dec}) <= 1), 32'd1);
      chk("pc_in_idle_zero", 32'(pc_load || (pc_in == 11'd0)), 32'd1);
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_instr: got addr %0h data %0h want none", instr_addr, instr_data);
        end else begin
          e = exp_q.pop_front();
          chk("instr_addr", 32'(instr_addr), 32'(e.addr));
          chk("instr_data", 32'(instr_data), 32'(e.data));
        end
        pops++;
        hs_cyc.push_back(cyc);
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_timeout"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({name, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({name, "_strobes"}, 32'({pc_load, pc_inc, pc_dec}), 32'd0);
    chk({name, "_busy_fault"}, 32'({busy, fault}), 32'd0);
    chk({name, "_regs"}, 32'({instr_data, instr_addr, mem_addr, pc_in}), 32'd0);
  endtask

  initial begin
    int base, i0, d0, l0, nreq, n;
    logic ok;
    logic [15:0] held;

    // Reset state
    #2;
    check_quiet("reset");
    @(negedge clk);
    pc_set = 1'b1;
    pc_set_val = 11'h005;
    @(negedge clk);
    pc_set = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_quiet("post_reset");

    // Basic fetch from 0x005
    push_exp(11'h005);
    base = req_log.size();
    do_start();
    wait_idle("basic");
    chk("basic_req_addr", 32'(req_log[base]), 32'h005);
    chk("basic_req_count", 32'(req_log.size() - base), 32'd1);
    chk("basic_inc", 32'(n_inc), 32'd1);
    chk("basic_pc", 32'(pc), 32'h006);
    push_exp(11'h006);
    do_start();
    wait_idle("second");
    chk("second_req_addr", 32'(req_log[req_log.size()-1]), 32'h006);

    // Backpressure on both sides
    i0 = n_inc;
    push_exp(11'h007);
    mem_req_ready = 1'b0;
    instr_ready = 1'b0;
    do_start();
    ok = 1'b1;
    repeat (4) begin
      if (!(mem_req_valid && mem_addr == 11'h007)) ok = 1'b0;
      @(negedge clk);
    end
    chk("stall_addr_stable", 32'(ok), 32'd1);
    mem_req_ready = 1'b1;
    n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_instr_valid", 32'(instr_valid), 32'd1);
    held = instr_data;
    ok = 1'b1;
    repeat (5) begin
      if (!instr_valid || instr_data !== held) ok = 1'b0;
      @(negedge clk);
    end
    chk("stall_instr_stable", 32'(ok), 32'd1);
    chk("stall_inc_once", 32'(n_inc - i0), 32'd1);
    instr_ready = 1'b1;
    wait_idle("stall");
    chk("stall_pc", 32'(pc), 32'h008);

    // Jump and rewind together: jump wins
    d0 = n_dec;
    l0 = n_load;
    push_exp(11'h008);
    jump_req = 1'b1;
    rewind = 1'b1;
    jump_addr = 11'h3F0;
    do_start();
    n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("jump_load", 32'({pc_load, pc_dec}), 32'b10);
    chk("jump_pc_in", 32'(pc_in), 32'h3F0);
    wait_idle("jump");
    jump_req = 1'b0;
    rewind = 1'b0;
    chk("jump_counts", 32'({16'(n_load - l0), 16'(n_dec - d0)}), {16'd1, 16'd0});
    push_exp(11'h3F0);
    do_start();
    wait_idle("after_jump");
    chk("after_jump_addr", 32'(req_log[req_log.size()-1]), 32'h3F0);

    // Rewind alone
    d0 = n_dec;
    push_exp(11'h3F1);
    rewind = 1'b1;
    do_start();
    wait_idle("rewind");
    rewind = 1'b0;
    chk("rewind_dec", 32'(n_dec - d0), 32'd1);
    chk("rewind_pc", 32'(pc), 32'h3F1);
    push_exp(11'h3F1);
    do_start();
    wait_idle("refetch");
    chk("refetch_addr", 32'(req_log[req_log.size()-1]), 32'h3F1);

    // Two errors then success
    i0 = n_inc;
    base = req_log.size();
    err_left = 2;
    push_exp(11'h3F2);
    do_start();
    wait_idle("retry");
    nreq = req_log.size() - base;
    chk("retry_req_count", 32'(nreq), 32'd3);
    ok = 1'b1;
    for (int k = base; k < req_log.size(); k++) if (req_log[k] != 11'h3F2) ok = 1'b0;
    chk("retry_same_addr", 32'(ok), 32'd1);
    chk("retry_inc_once", 32'(n_inc - i0), 32'd1);
    chk("retry_fault_clear", 32'(fault), 32'd0);

    // Three errors -> fault, then restart
    i0 = n_inc;
    base = req_log.size();
    err_left = 3;
    do_start();
    wait_idle("fault");
    chk("fault_set", 32'({fault, busy}), 32'b10);
    chk("fault_req_count", 32'(req_log.size() - base), 32'd3);
    chk("fault_no_inc", 32'(n_inc - i0), 32'd0);
    push_exp(11'h3F3);
    do_start();
    chk("fault_cleared", 32'({fault, busy}), 32'b01);
    wait_idle("resume");
    chk("resume_addr", 32'(req_log[req_log.size()-1]), 32'h3F3);

    // Continuous fetch, then halt; throughput 3 cycles per instruction
    base = pops;
    halt = 1'b0;
    push_exp(11'h3F4);
    push_exp(11'h3F5);
    do_start();
    n = 0;
    while (pops == base && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    halt = 1'b1;
    wait_idle("halt");
    chk("halt_pops", 32'(pops - base), 32'd2);
    chk("throughput", 32'(hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2]), 32'd3);
    nreq = req_log.size();
    repeat (5) @(negedge clk);
    chk("halt_no_req", 32'(req_log.size() - nreq), 32'd0);

    // Reset during WAIT; late response must be ignored
    base = pops;
    rsp_block = 1'b1;
    do_start();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_quiet("rst_wait");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("rst_release");
    rsp_block = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (instr_valid || busy) ok = 1'b0;
    end
    chk("rst_rsp_ignored", 32'(ok), 32'd1);
    chk("rst_no_pop", 32'(pops - base), 32'd0);
    chk("rst_pc_unchanged", 32'(pc), 32'h3F6);
    push_exp(11'h3F6);
    do_start();
    wait_idle("rst_restart");
    chk("rst_restart_pc", 32'(pc), 32'h3F7);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
